// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - load/store size encodings shared by the decoder and the LSU
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LANE_B = 2'd0,
        LANE_H = 2'd1,
        LANE_W = 2'd2
    } lane_e;

    // Store lane width; the unsigned codes share their signed width and
    // every unassigned code falls back to a full word.
    function automatic lane_e size_lane(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return LANE_B;
            2'b01:   return LANE_H;
            default: return LANE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects and extends the loaded byte/half/word from the memory word
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [1:0]  off_q,
    input  logic [2:0]  size_q,
    output logic [31:0] core_rd_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            LDST_B:  core_rd_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: core_rd_o = {24'h000000, byte_sel};
            LDST_H:  core_rd_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: core_rd_o = {16'h0000, half_sel};
            default: core_rd_o = mem_rd_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - single-cycle-stall load-store unit; LSU_MISALIGN_EN enables misaligned-access trapping
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
);

    logic       stall_q, stall_d;
    logic [1:0] off_q, off_d;
    logic [2:0] size_q, size_d;
    logic       misalign;

`ifdef LSU_MISALIGN_EN
    logic half_acc, word_acc;
    always_comb begin
        half_acc = (core_size_i == LDST_H) || (core_size_i == LDST_HU);
        word_acc = (core_size_i == LDST_W);
        misalign = core_req_i & ((half_acc & core_addr_i[0]) | (word_acc & |core_addr_i[1:0]));
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= LDST_W;
        end else begin
            stall_q <= stall_d;
            off_q   <= off_d;
            size_q  <= size_d;
        end
    end

    // The stall is its own release: a stalled cycle is always followed by a free one.
    always_comb begin
        stall_d = core_stall_o;
        off_d   = off_q;
        size_d  = size_q;
        if (mem_req_o) begin
            off_d  = core_addr_i[1:0];
            size_d = core_size_i;
        end
    end

    always_comb begin
        core_stall_o = core_req_i & ~stall_q & ~misalign;
        mem_req_o    = core_stall_o;
        mem_we_o     = core_we_i & mem_req_o;
        misalign_o   = misalign;
        mem_addr_o   = {core_addr_i[ADDR_W-1:2], 2'b00};
        mem_be_o     = 4'b1111;
        mem_wd_o     = core_wd_i;
        case (size_lane(core_size_i))
            LANE_B: begin
                mem_wd_o = {4{core_wd_i[7:0]}};
                if (core_we_i) mem_be_o = 4'b0001 << core_addr_i[1:0];
            end
            LANE_H: begin
                mem_wd_o = {2{core_wd_i[15:0]}};
                if (core_we_i) mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .mem_rd_i  (mem_rd_i),
        .off_q     (off_q),
        .size_q    (size_q),
        .core_rd_o (core_rd_o)
    );

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed bench for riscv_lsu (default build, misalign trapping off)
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall, misalign;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int checks = 0;
    int failures = 0;

    riscv_lsu #(.ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .misalign_o   (misalign),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        #1;
    endtask

    // Advance to the release cycle, present the memory word and drop the request.
    task automatic release_cycle(input logic [31:0] word);
        @(negedge clk);
        mem_rd = word;
        #1;
        chk("stall_released", {31'd0, core_stall}, 32'd0);
        chk("mem_req_released", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'b010;
        core_addr = 32'h0; core_wd = 32'h0; mem_rd = 32'h12345678;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {31'd0, core_stall}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        chk("reset_rd_word", core_rd, 32'h12345678);
        core_req = 1'b1;
        #1;
        chk("reset_stall_follows_req", {31'd0, core_stall}, 32'd1);
        chk("reset_memreq_follows_req", {31'd0, mem_req}, 32'd1);
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // LW 0x100
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_stall", {31'd0, core_stall}, 32'd1);
        chk("lw_mem_req", {31'd0, mem_req}, 32'd1);
        chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_be", {28'd0, mem_be}, 32'hF);
        release_cycle(32'hDEADBEEF);
        chk("lw_rd", core_rd, 32'hDEADBEEF);
        core_req = 1'b0;

        // LB / LBU 0x103
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_addr", mem_addr, 32'h100);
        release_cycle(32'h80FF7F01);
        chk("lb_rd", core_rd, 32'hFFFFFF80);
        core_req = 1'b0;
        #1;
        chk("lb_rd_holds_idle", core_rd, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        release_cycle(32'h80FF7F01);
        chk("lbu_rd", core_rd, 32'h00000080);
        core_req = 1'b0;

        // LH 0x102 / LHU 0x100
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        release_cycle(32'h80FF7F01);
        chk("lh_rd", core_rd, 32'hFFFF80FF);
        core_req = 1'b0;
        issue(1'b0, 3'b101, 32'h100, 32'h0);
        release_cycle(32'h80FF7F01);
        chk("lhu_rd", core_rd, 32'h00007F01);
        core_req = 1'b0;

        // SH 0x1234ABCD at 0x202
        issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        chk("sh_be", {28'd0, mem_be}, 32'hC);
        chk("sh_wd", mem_wd, 32'hABCDABCD);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        chk("sh_addr", mem_addr, 32'h200);
        release_cycle(32'h0);
        chk("sh_we_released", {31'd0, mem_we}, 32'd0);
        core_req = 1'b0;

        // SB at 0x201, SW at 0x300, illegal size 3 at 0x301
        issue(1'b1, 3'b000, 32'h201, 32'h000000A5);
        chk("sb_be", {28'd0, mem_be}, 32'h2);
        chk("sb_wd", mem_wd, 32'hA5A5A5A5);
        release_cycle(32'h0);
        core_req = 1'b0;
        issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        chk("sw_be", {28'd0, mem_be}, 32'hF);
        chk("sw_wd", mem_wd, 32'hCAFEF00D);
        release_cycle(32'h0);
        core_req = 1'b0;
        issue(1'b1, 3'b011, 32'h301, 32'h87654321);
        chk("illegal_be", {28'd0, mem_be}, 32'hF);
        chk("illegal_wd", mem_wd, 32'h87654321);
        release_cycle(32'h0);
        core_req = 1'b0;

        // Back-to-back loads: request held high for four cycles
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        chk("b2b_c0_stall", {31'd0, core_stall}, 32'd1);
        @(negedge clk); #1;
        chk("b2b_c1_stall", {31'd0, core_stall}, 32'd0);
        @(negedge clk); #1;
        chk("b2b_c2_stall", {31'd0, core_stall}, 32'd1);
        chk("b2b_c2_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk); #1;
        chk("b2b_c3_stall", {31'd0, core_stall}, 32'd0);
        core_req = 1'b0;

        // Reset pulsed in the release cycle with the request held
        issue(1'b0, 3'b010, 32'h500, 32'h0);
        chk("rst_n_stall", {31'd0, core_stall}, 32'd1);
        @(negedge clk); #1;
        chk("rst_n1_stall", {31'd0, core_stall}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", {31'd0, core_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_reissue_stall", {31'd0, core_stall}, 32'd1);
        chk("rst_reissue_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk); #1;
        chk("rst_reissue_release", {31'd0, core_stall}, 32'd0);
        core_req = 1'b0;

        // Flush: request dropped in the release cycle, then a fresh request
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk("flush_stall", {31'd0, core_stall}, 32'd0);
        issue(1'b0, 3'b010, 32'h604, 32'h0);
        chk("flush_next_stall", {31'd0, core_stall}, 32'd1);
        release_cycle(32'h0);
        core_req = 1'b0;

        // Misaligned word/half without trapping: lanes only
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        chk("mis_lw_flag", {31'd0, misalign}, 32'd0);
        chk("mis_lw_stall", {31'd0, core_stall}, 32'd1);
        chk("mis_lw_addr", mem_addr, 32'h100);
        release_cycle(32'h11223344);
        chk("mis_lw_rd", core_rd, 32'h11223344);
        core_req = 1'b0;
        issue(1'b0, 3'b001, 32'h103, 32'h0);
        release_cycle(32'h80FF7F01);
        chk("mis_lh_rd", core_rd, 32'hFFFF80FF);
        core_req = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
